// File: rtl/disp_mode_ctrl.sv
// Frame-aligned VGA/XGA mode switch sequencer for the pattern-generator path.
// Optional lock-timeout revert is enabled by defining LOCK_TIMEOUT_EN.
module disp_mode_ctrl #(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_SETTLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic DCLK,
    input  logic RST_X,
    input  logic BTNR_TGL,
    input  logic DSP_VSYNC_X,
    input  logic CLK_LOCKED,
    output logic XGA,
    output logic CLK_SEL,
    output logic TG_RST,
    output logic BLANK,
    output logic BUSY,
    output logic MODE_ERR
);

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int SW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam int CW = (HW > SW) ? HW : SW;
    localparam logic [CW-1:0] HOLD_END   = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] SETTLE_END = CW'(LOCK_SETTLE - 1);

    if (RST_HOLD < 1 || LOCK_SETTLE < 1 || LOCK_TIMEOUT < 1) begin : g_param_chk
        $error("disp_mode_ctrl: parameters must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS,
        HOLD,
        WAIT_LOCK,
        RELEASE,
        WAIT_FRAME
    } state_t;

    state_t state, state_nxt;

    logic          btn_s1, btn_s2;
    logic          lock_s1, lock_s2;
    logic          vs_q;
    logic          vs_fall;
    logic          xga_q, xga_nxt;
    logic          clk_sel_q, clk_sel_nxt;
    logic          tg_rst_q, tg_rst_nxt;
    logic          blank_q, blank_nxt;
    logic          tgt, tgt_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          settle_done;

    always_ff @(posedge DCLK) begin
        if (!RST_X) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            btn_s1  <= BTNR_TGL;
            btn_s2  <= btn_s1;
            lock_s1 <= CLK_LOCKED;
            lock_s2 <= lock_s1;
            vs_q    <= DSP_VSYNC_X;
        end
    end

    assign vs_fall     = vs_q & ~DSP_VSYNC_X;
    assign settle_done = lock_s2 && (cnt == SETTLE_END);

`ifdef LOCK_TIMEOUT_EN
    localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_END = TW'(LOCK_TIMEOUT - 1);

    logic [TW-1:0] tcnt, tcnt_nxt;
    logic          rev, rev_nxt;
    logic          mode_err_q, mode_err_nxt;

    // rev resets high so the post-reset lock wait never times out
    always_ff @(posedge DCLK) begin
        if (!RST_X) begin
            tcnt       <= '0;
            rev        <= 1'b1;
            mode_err_q <= 1'b0;
        end else begin
            tcnt       <= tcnt_nxt;
            rev        <= rev_nxt;
            mode_err_q <= mode_err_nxt;
        end
    end

    assign MODE_ERR = mode_err_q;
`else
    assign MODE_ERR = 1'b0;
`endif

    always_ff @(posedge DCLK) begin
        if (!RST_X) begin
            state     <= WAIT_LOCK;
            xga_q     <= 1'b0;
            clk_sel_q <= 1'b0;
            tg_rst_q  <= 1'b1;
            blank_q   <= 1'b1;
            tgt       <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            xga_q     <= xga_nxt;
            clk_sel_q <= clk_sel_nxt;
            tg_rst_q  <= tg_rst_nxt;
            blank_q   <= blank_nxt;
            tgt       <= tgt_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (btn_s2 != xga_q) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (btn_s2 == xga_q) state_nxt = IDLE;
                else if (vs_fall)    state_nxt = HOLD;
            end
            HOLD: begin
                if (cnt == HOLD_END) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (settle_done) state_nxt = RELEASE;
            end
            RELEASE: begin
                state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vs_fall && !tg_rst_q) state_nxt = IDLE;
            end
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    always_comb begin
        xga_nxt     = xga_q;
        clk_sel_nxt = clk_sel_q;
        tg_rst_nxt  = tg_rst_q;
        blank_nxt   = blank_q;
        tgt_nxt     = tgt;
        cnt_nxt     = cnt;
`ifdef LOCK_TIMEOUT_EN
        tcnt_nxt     = tcnt;
        rev_nxt      = rev;
        mode_err_nxt = mode_err_q;
`endif
        unique case (state)
            IDLE: begin
                tg_rst_nxt = 1'b0;
                blank_nxt  = 1'b0;
            end
            WAIT_VS: begin
                if (btn_s2 != xga_q && vs_fall) begin
                    tgt_nxt    = btn_s2;
                    blank_nxt  = 1'b1;
                    tg_rst_nxt = 1'b1;
                    cnt_nxt    = '0;
`ifdef LOCK_TIMEOUT_EN
                    tcnt_nxt   = '0;
                    rev_nxt    = 1'b0;
`endif
                end
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    clk_sel_nxt = tgt;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (!lock_s2 || settle_done) cnt_nxt = '0;
                else                         cnt_nxt = cnt + CW'(1);
`ifdef LOCK_TIMEOUT_EN
                // a completed settle wins over a coincident timeout
                if (!rev && !settle_done) begin
                    if (tcnt == TO_END) begin
                        mode_err_nxt = 1'b1;
                        clk_sel_nxt  = xga_q;
                        rev_nxt      = 1'b1;
                        cnt_nxt      = '0;
                        tcnt_nxt     = '0;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
`endif
            end
            RELEASE: begin
                xga_nxt    = clk_sel_q;
                tg_rst_nxt = 1'b0;
`ifdef LOCK_TIMEOUT_EN
                if (clk_sel_q == tgt) mode_err_nxt = 1'b0;
`endif
            end
            WAIT_FRAME: begin
                if (vs_fall && !tg_rst_q) blank_nxt = 1'b0;
            end
            default: begin
                tg_rst_nxt = 1'b1;
                blank_nxt  = 1'b1;
            end
        endcase
    end

    assign XGA     = xga_q;
    assign CLK_SEL = clk_sel_q;
    assign TG_RST  = tg_rst_q;
    assign BLANK   = blank_q;
    assign BUSY    = (state != IDLE);

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Table-driven bench for disp_mode_ctrl with RST_HOLD=4, LOCK_SETTLE=8, LOCK_TIMEOUT=100.
// Output vector order: {XGA, CLK_SEL, TG_RST, BLANK, BUSY, MODE_ERR}.
module tb_disp_mode_ctrl;

  logic clk = 1'b0;
  logic rst_x, btn, vs, lock;
  logic xga, clk_sel, tg_rst, blank, busy, mode_err;

  disp_mode_ctrl #(
    .RST_HOLD(4),
    .LOCK_SETTLE(8),
    .LOCK_TIMEOUT(100)
  ) dut (
    .DCLK(clk),
    .RST_X(rst_x),
    .BTNR_TGL(btn),
    .DSP_VSYNC_X(vs),
    .CLK_LOCKED(lock),
    .XGA(xga),
    .CLK_SEL(clk_sel),
    .TG_RST(tg_rst),
    .BLANK(blank),
    .BUSY(busy),
    .MODE_ERR(mode_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    bit         rst_x;
    bit         btn;
    bit         vs;
    bit         lock;
    logic [5:0] exp;
    string      tag;
  } vec_t;

  vec_t       tbl[$];
  logic [5:0] sb_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic add(input int n, input bit r,
                     input bit b, input bit v,
                     input bit l, input logic [5:0] e,
                     input string t);
    vec_t x;
    x.n = n; x.rst_x = r; x.btn = b;
    x.vs = v; x.lock = l;
    x.exp = e; x.tag = t;
    tbl.push_back(x);
  endtask

  task automatic chk(input logic [5:0] want,
                     input string t);
    logic [5:0] got;
    got = {xga, clk_sel, tg_rst,
           blank, busy, mode_err};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%b want=%b",
               t, got, want);
    end
  endtask

  initial begin
    logic [5:0] want;

    rst_x = 1'b0;
    btn   = 1'b0;
    vs    = 1'b1;
    lock  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(6'b001110, "reset_state");

    add(2,  0, 0, 1, 1, 6'b001110, "rst");
    add(10, 1, 0, 1, 1, 6'b001110, "t1_settle");
    add(1,  1, 0, 1, 1, 6'b000110, "t1_release");
    add(5,  1, 0, 1, 1, 6'b000110, "t1_wait_frame");
    add(1,  1, 0, 0, 1, 6'b000000, "t1_idle");
    add(3,  1, 0, 0, 1, 6'b000000, "t1_idle_hold");
    add(2,  1, 1, 1, 1, 6'b000000, "t2_sync");
    add(1,  1, 1, 1, 1, 6'b000010, "t2_wait_vs");
    add(10, 1, 1, 1, 1, 6'b000010, "t2_mid_frame");
    add(1,  1, 1, 0, 1, 6'b001110, "t2_hold");
    add(3,  1, 1, 0, 1, 6'b001110, "t2_hold_cnt");
    add(1,  1, 1, 0, 1, 6'b011110, "t2_clk_sel");
    add(8,  1, 1, 0, 1, 6'b011110, "t2_settle");
    add(1,  1, 1, 0, 1, 6'b110110, "t2_commit");
    add(2,  1, 1, 1, 1, 6'b110110, "t2_frame");
    add(1,  1, 1, 0, 1, 6'b110000, "t2_idle");
    add(2,  1, 1, 0, 1, 6'b110000, "t2_stay");
    add(3,  1, 0, 1, 1, 6'b110010, "t3_req");
    add(2,  1, 1, 1, 1, 6'b110010, "t3_back");
    add(1,  1, 1, 0, 1, 6'b110000, "t3_cancel");
    add(2,  1, 1, 0, 1, 6'b110000, "t3_no_switch");
    add(3,  1, 0, 1, 1, 6'b110010, "t6_req");
    add(2,  1, 0, 0, 1, 6'b111110, "t6_hold");
    add(1,  0, 0, 0, 1, 6'b001110, "t6_reset");
    add(10, 1, 0, 1, 1, 6'b001110, "t6_settle");
    add(1,  1, 0, 1, 1, 6'b000110, "t6_release");
    add(1,  1, 0, 0, 1, 6'b000000, "t6_idle");
    add(3,  1, 1, 1, 1, 6'b000010, "t4_req");
    add(1,  1, 1, 0, 1, 6'b001110, "t4_hold");
    add(4,  1, 1, 0, 1, 6'b011110, "t4_lock_wait");
    add(3,  1, 1, 0, 1, 6'b011110, "t4_cnt3");
    add(1,  1, 1, 0, 0, 6'b011110, "t4_glitch");
    add(10, 1, 1, 0, 1, 6'b011110, "t4_restart");
    add(1,  1, 1, 0, 1, 6'b110110, "t4_commit");
    add(1,  1, 1, 1, 1, 6'b110110, "t4_frame");
    add(1,  1, 1, 0, 1, 6'b110000, "t4_idle");
    add(3,  1, 0, 1, 1, 6'b110010, "t5_vga_req");
    add(1,  1, 0, 0, 1, 6'b111110, "t5_hold");
    add(4,  1, 0, 0, 1, 6'b101110, "t5_sel");
    add(8,  1, 0, 0, 1, 6'b101110, "t5_settle");
    add(1,  1, 0, 0, 1, 6'b000110, "t5_commit");
    add(1,  1, 0, 1, 1, 6'b000110, "t5_frame");
    add(1,  1, 0, 0, 1, 6'b000000, "t5_idle");
    add(3,  1, 1, 1, 1, 6'b000010, "t5_xga_req");
    add(1,  1, 1, 0, 1, 6'b001110, "t5_hold2");
    add(4,  1, 1, 0, 0, 6'b011110, "t5_nolock");
    add(99, 1, 1, 0, 0, 6'b011110, "t5_wait");
`ifdef LOCK_TIMEOUT_EN
    add(1,   1, 1, 0, 0, 6'b001111, "t5_timeout");
    add(150, 1, 1, 0, 0, 6'b001111, "t5_revert_wait");
    add(10,  1, 1, 0, 1, 6'b001111, "t5_relock");
    add(1,   1, 1, 0, 1, 6'b000111, "t5_release");
    add(1,   1, 1, 1, 1, 6'b000111, "t5_frame2");
    add(1,   1, 1, 0, 1, 6'b000001, "t5_idle_err");
`else
    add(1,   1, 1, 0, 0, 6'b011110, "t5_no_timeout");
    add(150, 1, 1, 0, 0, 6'b011110, "t5_wait_forever");
    add(10,  1, 1, 0, 1, 6'b011110, "t5_relock");
    add(1,   1, 1, 0, 1, 6'b110110, "t5_release");
    add(1,   1, 1, 1, 1, 6'b110110, "t5_frame2");
    add(1,   1, 1, 0, 1, 6'b110000, "t5_idle");
`endif

    foreach (tbl[i]) begin
      rst_x = tbl[i].rst_x;
      btn   = tbl[i].btn;
      vs    = tbl[i].vs;
      lock  = tbl[i].lock;
      sb_q.push_back(tbl[i].exp);
      repeat (tbl[i].n) @(posedge clk);
      #1;
      want = sb_q.pop_front();
      chk(want, tbl[i].tag);
    end

`ifdef LOCK_TIMEOUT_EN
    chk(6'b000001, "expired_wait");
`else
    chk(6'b110000, "expired_wait");
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
Sequences VGA/XGA resolution changes for the pattern-generator display path.
- Converts the BTNR_TGL level request into a safe, frame-aligned mode switch.
- Switch sequence: wait for frame end, blank output, hold timing generator in reset, switch pixel-clock select, wait for clock lock to settle, release reset, publish XGA.
- Sits between the button/toggle logic, the clock mux/MMCM and the timing generator (patgen).

Parameters:
RST_HOLD, 16, DCLK cycles TG_RST held before CLK_SEL changes (min 1)
LOCK_SETTLE, 64, consecutive cycles CLK_LOCKED must stay high before release (min 1)
LOCK_TIMEOUT, 65535, max cycles in WAIT_LOCK before revert (only with the optional feature)

Ports:
DCLK  in  1  pixel clock; all logic on rising edge
RST_X  in  1  synchronous active-low reset
BTNR_TGL  in  1  async level, requested mode: 1=XGA, 0=VGA
DSP_VSYNC_X  in  1  active-low vsync from timing generator
CLK_LOCKED  in  1  async lock from clock generator
XGA  out  1  current committed mode, changes only at RELEASE
CLK_SEL  out  1  pixel-clock select to clock mux: 1=65 MHz, 0=25 MHz
TG_RST  out  1  active-high reset to timing generator
BLANK  out  1  force DSP_DE/RGB to 0 downstream
BUSY  out  1  high in every state except IDLE
MODE_ERR  out  1  sticky lock-timeout flag

Behaviour:
- BTNR_TGL and CLK_LOCKED each pass a 2-FF synchronizer (2-cycle latency).
- DSP_VSYNC_X registered once; vs_fall = prev 1, current 0.
- Reset (RST_X=0 at edge):
  - State=WAIT_LOCK; XGA=0, CLK_SEL=0, TG_RST=1, BLANK=1, MODE_ERR=0, counters=0.
  - BUSY=1; tgt=0.
  - Same result for reset mid-operation, from any state.
- States:
  - IDLE: TG_RST=0, BLANK=0. If sync(BTNR_TGL) != XGA, go to WAIT_VS.
  - WAIT_VS: if sync(BTNR_TGL) == XGA, go to IDLE (cancel). Else on vs_fall: latch tgt=sync(BTNR_TGL), set BLANK=1 and TG_RST=1 at the next edge, clear cnt, go to HOLD. Cancel takes priority over vs_fall in the same cycle.
  - HOLD: cnt++. When cnt==RST_HOLD-1: CLK_SEL<=tgt, clear cnt, go to WAIT_LOCK.
  - WAIT_LOCK: cnt++ while sync(CLK_LOCKED)=1; cnt clears when it is 0. When cnt==LOCK_SETTLE-1, go to RELEASE.
  - RELEASE (1 cycle): XGA<=CLK_SEL, TG_RST<=0, clear MODE_ERR if CLK_SEL==tgt, go to WAIT_FRAME.
  - WAIT_FRAME: BLANK stays 1 until first vs_fall, then BLANK<=0 and go to IDLE. vs_fall is ignored while TG_RST=1.
- Request changes while BUSY (past WAIT_VS) are ignored. Because the request is level-based, IDLE re-evaluates it.
- Request to same mode: no action. Toggling twice before vsync: no switch.
- The XGA value never changes while TG_RST=0.
- Counters are sized by $clog2 of their parameter; no wrap occurs because each count ends at its terminal value.

Optional Feature:
Macro LOCK_TIMEOUT_EN.
- Defined: a timeout counter runs in WAIT_LOCK, independent of lock glitches and cleared on entry.
  - On reaching LOCK_TIMEOUT-1 while the revert flag is 0: MODE_ERR<=1, CLK_SEL<=XGA (revert), revert flag<=1, restart WAIT_LOCK.
  - The revert attempt has no timeout.
  - The timeout is inactive in the post-reset WAIT_LOCK.
- Undefined: WAIT_LOCK waits indefinitely; MODE_ERR tied to 0.

Test Plan:
Test parameters: RST_HOLD=4, LOCK_SETTLE=8, LOCK_TIMEOUT=100.
1. Reset release with CLK_LOCKED=1 -> TG_RST falls 8+2+1 cycles after sync; XGA=0; BLANK clears at first vs_fall; then BUSY=0.
2. BTNR_TGL 0->1 mid-frame -> no output change until vs_fall. Then BLANK=TG_RST=1 next edge; CLK_SEL=1 after 4 cycles; lock held -> XGA=1 8 cycles later; BLANK=0 after next vs_fall.
3. BTNR_TGL 0->1->0 before vs_fall -> returns to IDLE; CLK_SEL, XGA, TG_RST unchanged.
4. CLK_LOCKED drops for 1 cycle at settle count 5 -> settle restarts; XGA commits only after 8 consecutive locked cycles.
5. (LOCK_TIMEOUT_EN) CLK_LOCKED held 0 after switch to XGA -> after 100 cycles MODE_ERR=1, CLK_SEL=0; lock restored -> XGA stays 0, TG_RST released, MODE_ERR stays 1.
6. RST_X=0 during HOLD -> next edge TG_RST=1, CLK_SEL=0, XGA=0, state WAIT_LOCK.
